custom_round_robin_arbiter: RTL and testbench

- Cyclic round-robin arbiter that grants one shared resource to at most one of N requesters per clock cycle.
- Priority rotates so that the requester after the last granted one has highest priority. This guarantees starvation-free access.
- Sits between requesting agents and a shared resource. The output is a registered one-hot grant vector.

---
 rtl/custom_round_robin_arbiter.sv | 76 +++++++
 tb/tb_custom_round_robin_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/custom_round_robin_arbiter.sv
// ----------------------------------------------------------------------------
// custom_round_robin_arbiter
//
// Cyclic round-robin arbiter: at most one of N requesters owns the shared
// resource each cycle. The requester that follows the previous winner in
// cyclic order has the highest priority, so no active requester can starve.
// The grant is re-arbitrated on every clock edge and is never locked.
//
// Ports:
//   clock          in   1  system clock, all state updates on the rising edge
//   reset_an       in   1  synchronous active-low reset
//   user_requests  in   N  level-sensitive request vector, bit i = requester i
//   granted        out  N  registered grant vector, one-hot or all-zero
// ----------------------------------------------------------------------------
module custom_round_robin_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset_an,
  input  logic [N-1:0] user_requests,
  output logic [N-1:0] granted
);

  localparam int PW = (N > 2) ? $clog2(N) : 1;

  // Index of the most recent winner; the search starts just after it.
  logic [PW-1:0]  last_ptr_r;

  logic [PW:0]    shamt_s;
  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [N-1:0]   low_s;
  logic [2*N-1:0] back_s;
  logic [N-1:0]   grant_next_s;
  logic [PW-1:0]  winner_s;
  logic           any_req_s;

  // Rotate requests so the highest-priority index lands on bit 0, isolate
  // the lowest set bit, then rotate the one-hot result back into place.
  always_comb begin
    shamt_s      = {1'b0, last_ptr_r} + {{PW{1'b0}}, 1'b1};
    dbl_s        = {user_requests, user_requests} >> shamt_s;
    rot_s        = dbl_s[N-1:0];
    low_s        = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
    back_s       = {{N{1'b0}}, low_s} << shamt_s;
    grant_next_s = back_s[N-1:0] | back_s[2*N-1:N];
    any_req_s    = |user_requests;
  end

  // Encode the one-hot winner back into an index for the pointer.
  always_comb begin
    winner_s = last_ptr_r;
    for (int i = 0; i < N; i++) begin
      if (grant_next_s[i]) begin
        winner_s = PW'(i);
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Grant and pointer registers; reset makes requester 0 top priority.
  always_ff @(posedge clock) begin
    if (!reset_an) begin
      granted    <= {N{1'b0}};
      last_ptr_r <= PW'(N - 1);
    end else if (any_req_s) begin
      granted    <= grant_next_s;
      last_ptr_r <= winner_s;
    end else begin
      granted    <= {N{1'b0}};
      last_ptr_r <= last_ptr_r;
    end
  end

endmodule

// File: tb/tb_custom_round_robin_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for custom_round_robin_arbiter.
// A behavioural model (shortest cyclic distance from the last winner) is
// compared against the DUT on every negative edge; directed sequences pin the
// model with literal expectations, then random stimulus exercises it. A
// second instance with N=4 checks the full-load rotation period.
// ----------------------------------------------------------------------------
module tb_custom_round_robin_arbiter;

  localparam int N = 3;

  logic         clock = 1'b0;
  logic         reset_an;
  logic [N-1:0] user_requests;
  logic [N-1:0] granted;

  logic         reset4_an;
  logic [3:0]   req4;
  logic [3:0]   granted4;

  int total = 0;
  int bad   = 0;

  int           m_last;
  logic [N-1:0] exp_grant;
  logic [N-1:0] m_req;
  bit           model_valid = 1'b0;

  always #5 clock = ~clock;

  custom_round_robin_arbiter #(.N(N)) dut (
    .clock         (clock),
    .reset_an      (reset_an),
    .user_requests (user_requests),
    .granted       (granted)
  );

  custom_round_robin_arbiter #(.N(4)) dut4 (
    .clock         (clock),
    .reset_an      (reset4_an),
    .user_requests (req4),
    .granted       (granted4)
  );

  // Reference model: the winner is the active requester at the smallest
  // cyclic distance after the last winner.
  always @(posedge clock) begin : model
    int best;
    int bestd;
    int d;
    if (!reset_an) begin
      exp_grant = '0;
      m_last    = N - 1;
      m_req     = '0;
    end else begin
      best  = -1;
      bestd = N + 1;
      for (int i = 0; i < N; i++) begin
        if (user_requests[i]) begin
          d = (i - m_last - 1 + 2 * N) % N;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
      exp_grant = '0;
      if (best >= 0) begin
        exp_grant[best] = 1'b1;
        m_last          = best;
      end
      m_req = user_requests;
    end
    model_valid = 1'b1;
  end

  // Per-cycle compare of the DUT against the model and the invariants.
  always @(negedge clock) begin
    if (model_valid) begin
      total++;
      if (granted !== exp_grant) begin
        bad++;
        $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, granted, exp_grant);
      end
      total++;
      if (($countones(granted) > 1) || ((granted & ~m_req) != '0)) begin
        bad++;
        $display("FAIL invariant t=%0t got=%b req_at_edge=%b", $time, granted, m_req);
      end
    end
  end

  task automatic drive(input logic rst, input logic [N-1:0] req);
    reset_an      = rst;
    user_requests = req;
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string name, input logic [N-1:0] exp);
    total++;
    if (granted !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, granted, exp);
    end
  endtask

  initial begin
    logic [3:0] e4;
    reset_an      = 1'b0;
    user_requests = 3'b111;
    reset4_an     = 1'b0;
    req4          = 4'b1111;

    // Reset held with all requests high
    drive(1'b0, 3'b111); chk("reset_hold1", 3'b000);
    drive(1'b0, 3'b111); chk("reset_hold2", 3'b000);
    // Full-load rotation after release
    drive(1'b1, 3'b111); chk("rot_a", 3'b001);
    drive(1'b1, 3'b111); chk("rot_b", 3'b010);
    drive(1'b1, 3'b111); chk("rot_c", 3'b100);
    drive(1'b1, 3'b111); chk("rot_d", 3'b001);

    // Single requester after reset
    drive(1'b0, 3'b000); chk("single_rst", 3'b000);
    drive(1'b1, 3'b001); chk("single_on", 3'b001);
    drive(1'b1, 3'b000); chk("single_off", 3'b000);

    // Rotation skip (last winner 0)
    drive(1'b1, 3'b011); chk("skip_011", 3'b010);
    drive(1'b1, 3'b101); chk("skip_101", 3'b100);
    drive(1'b1, 3'b001); chk("skip_001", 3'b001);
    drive(1'b1, 3'b000); chk("skip_000", 3'b000);

    // Sole holder persistence, then a competitor joins
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b100); chk("sole_hold", 3'b100);
    end
    drive(1'b1, 3'b101); chk("sole_join", 3'b001);

    // Mid-operation reset
    drive(1'b1, 3'b010); chk("mid_pre", 3'b010);
    drive(1'b0, 3'b010); chk("mid_rst", 3'b000);
    drive(1'b1, 3'b011); chk("mid_post", 3'b001);

    // Random stimulus with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) != 0) ? 1'b1 : 1'b0, N'($urandom_range(0, 7)));
    end
    // Sustained full load inside the random phase
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 3'b111);
    end

    // N=4 instance: held in reset, then full load gives period 4
    total++;
    if (granted4 !== 4'b0000) begin
      bad++;
      $display("FAIL n4_reset t=%0t got=%b exp=%b", $time, granted4, 4'b0000);
    end
    reset4_an = 1'b1;
    @(posedge clock);
    #2;
    for (int i = 0; i < 9; i++) begin
      e4 = 4'b0001 << (i % 4);
      total++;
      if (granted4 !== e4) begin
        bad++;
        $display("FAIL n4_rotate t=%0t got=%b exp=%b", $time, granted4, e4);
      end
      @(posedge clock);
      #2;
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
